hdb3_decoder: RTL and testbench
===============================

Name: hdb3_decoder

Overview:
- Receive-side counterpart of the HDB3 encoding chain. Takes the encoded ternary symbol stream (+1 / 0 / -1) one symbol per enabled clock and recovers the original binary stream.
- Detects V (bipolar violation) pulses and removes each V together with its B pulse, if present, by zeroing the 4-symbol substitution group.
- Flags malformed code and counts V events.
- Sits between the line-receive/symbol-sampling stage and the downstream data sink.

Parameters:
- SYM_P, 2'b01, code for +1 pulse
- SYM_N, 2'b11, code for -1 pulse
- SYM_Z, 2'b00, code for zero; 2'b10 is illegal
- CNT_W, 16, width of the V event counter

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  symbol strobe; hdb3_data is sampled only on clock edges where en=1
- hdb3_data  input  2  encoded symbol (SYM_P/SYM_N/SYM_Z)
- decoded_data  output  1  recovered bit, registered
- out_valid  output  1  one-cycle strobe: decoded_data was updated this edge
- code_err  output  1  one-cycle strobe: illegal symbol or malformed V
- v_count  output  CNT_W  number of V pulses detected; saturates at all-ones

Behaviour:
- Reset (rst=1, async): decoded_data=0, out_valid=0, code_err=0, v_count=0.
  - Reset also clears the shift register, fill counter, and last-polarity register, and clears pol_valid.
  - Asserting rst mid-stream discards all in-flight symbols. The first symbols after release restart the fill.
- en=0: all state holds. out_valid=0 and code_err=0 on that cycle. decoded_data holds its value.
- Per enabled symbol:
  - mark = (symbol != SYM_Z).
  - pol = 1 for SYM_P, 0 for SYM_N.
  - SYM_Z is treated as a zero.
  - The illegal code 2'b10 is treated as zero and pulses code_err.
- V detection: a symbol is V when mark=1, pol_valid=1, and pol equals last_pol. Otherwise it is a normal mark.
  - Every mark, including V, updates last_pol and sets pol_valid.
  - The first mark after reset is never V.
- Delay line: 4-entry bit register sr[3:0] plus raw-mark flags m[3:0].
  - On each enabled edge, decoded_data <= sr[3], then sr <= {sr[2:0], new_bit}.
  - Normal: new_bit = mark.
  - On V: new_bit = 0, and sr[2:0] is cleared in the same edge. This removes the B00V or 000V group.
  - sr[3] leaves on that same edge and is not affected.
- Malformed V: if V is detected while m[0] or m[1] is set (either of the two symbols just before V was nonzero), code_err pulses. Decoding still zeros the group.
- Latency: the bit of the symbol accepted on enabled edge k appears on decoded_data at enabled edge k+4, regardless of idle cycles in between.
- Fill: a counter 0..4 increments on each enabled edge until it reaches 4.
  - out_valid=1 only on enabled edges where the counter already equals 4, i.e. from the 5th enabled symbol after reset onward.
  - Before that, decoded_data stays 0.
- v_count increments by 1 on each detected V and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous illegal symbol and V: impossible, because an illegal symbol is not a mark. An illegal symbol and a fill edge can coincide; both code_err and out_valid behave independently.

Decomposition:
- Package hdb3_pkg holds SYM_P, SYM_N, SYM_Z and the illegal code constant. It is shared with the encoder chain.
- Sub-module hdb3_v_detector holds the polarity tracker (last_pol, pol_valid). Its outputs are combinational is_mark and is_v for the current symbol.
- The top level holds the delay line, fill counter, error logic and counter.

Test Plan:
- 000V case: after reset, drive en=1 with symbols 01,00,00,00,01,11, then four 00. The V is at symbol 5.
  - Required: out_valid starts at the 5th edge.
  - decoded_data sequence is 1,0,0,0,0,1,0,0,0,0.
  - v_count=1; code_err never pulses.
- B00V case: symbols 01,11,01,00,00,01, then four 00. The B is symbol 3 and the V is symbol 6.
  - Required: decoded sequence 1,1,0,0,0,0,0,0,0,0.
  - v_count=1.
- en gaps: repeat the 000V case with en=0 for 3 cycles between every symbol.
  - Required: identical decoded sequence.
  - out_valid only pulses on en cycles; state holds during the gaps.
- Illegal code: symbols 01,10,00,00,01 (the 4th symbol is 00).
  - Required: code_err pulses exactly on the edge that samples 10, and the 10 decodes as 0.
  - Symbol 5 is V (same polarity as symbol 1); m[0] and m[1] are clear, so there is no second error.
- Malformed V: symbols 01,00,01.
  - Required: symbol 3 is V with m[1] set, so code_err pulses at edge 3 and v_count=1.
- Reset mid-stream: assert rst asynchronously after 3 symbols, then release.
  - Required: all outputs go to 0 immediately.
  - The next mark is not V, and out_valid resumes only after 4 new enabled symbols.
  - Also force v_count to saturation via a CNT_W=2 build: after 5 V events v_count holds at 3.

Source files
------------

// File: rtl/hdb3_pkg.sv
// hdb3_pkg: symbol codes and helpers shared by the HDB3 encode/decode chain.
//   SYM_P / SYM_N / SYM_Z : +1 / -1 / zero line symbols
//   SYM_ILL               : the one illegal 2-bit code
//   FILL_MAX              : depth of the decoder delay line (substitution group length)
package hdb3_pkg;

    localparam logic [1:0] SYM_P   = 2'b01;
    localparam logic [1:0] SYM_N   = 2'b11;
    localparam logic [1:0] SYM_Z   = 2'b00;
    localparam logic [1:0] SYM_ILL = 2'b10;

    localparam logic [2:0] FILL_MAX = 3'd4;

    function automatic logic sym_is_mark(input logic [1:0] sym);
        return (sym == SYM_P) || (sym == SYM_N);
    endfunction

    function automatic logic sym_is_illegal(input logic [1:0] sym);
        return sym == SYM_ILL;
    endfunction

endpackage

// File: rtl/hdb3_v_detector.sv
// hdb3_v_detector: tracks the polarity of the last mark and flags bipolar violations.
//   clk, rst  : clock, async active-high reset
//   en        : symbol strobe; polarity state only advances when en=1
//   sym       : current encoded symbol
//   is_mark   : current symbol is a +1 or -1 pulse (combinational)
//   is_v      : current symbol repeats the previous mark polarity (combinational)
module hdb3_v_detector (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] sym,
    output logic       is_mark,
    output logic       is_v
);
    import hdb3_pkg::*;

    logic pol;
    logic last_pol_q, last_pol_d;
    logic pol_valid_q, pol_valid_d;

    always_comb begin
        is_mark     = sym_is_mark(sym);
        pol         = (sym == SYM_P);
        // No reference polarity exists until the first mark, so it can never be V.
        is_v        = is_mark && pol_valid_q && (pol == last_pol_q);
        last_pol_d  = last_pol_q;
        pol_valid_d = pol_valid_q;
        if (en && is_mark) begin
            last_pol_d  = pol;
            pol_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pol_q  <= 1'b0;
            pol_valid_q <= 1'b0;
        end else begin
            last_pol_q  <= last_pol_d;
            pol_valid_q <= pol_valid_d;
        end
    end

endmodule

// File: rtl/hdb3_decoder.sv
// hdb3_decoder: recovers the binary stream from an HDB3 ternary symbol stream.
//   clk, rst     : clock, async active-high reset
//   en           : symbol strobe; hdb3_data sampled only when en=1
//   hdb3_data    : encoded symbol (SYM_P / SYM_N / SYM_Z)
//   decoded_data : recovered bit, four enabled symbols behind the input
//   out_valid    : strobe, decoded_data updated on this edge (after the delay line fills)
//   code_err     : strobe, illegal symbol or V preceded by a nonzero in the last two slots
//   v_count      : saturating count of detected V pulses
module hdb3_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       hdb3_data,
    output logic             decoded_data,
    output logic             out_valid,
    output logic             code_err,
    output logic [CNT_W-1:0] v_count
);
    import hdb3_pkg::*;

    logic is_mark;
    logic is_v;

    logic [3:0]       sr_q, sr_d;
    // Only the two most recent raw-mark flags are ever inspected.
    logic [1:0]       m_q, m_d;
    logic [2:0]       fill_q, fill_d;
    logic             decoded_q, decoded_d;
    logic             out_valid_q, out_valid_d;
    logic             code_err_q, code_err_d;
    logic [CNT_W-1:0] v_count_q, v_count_d;

    hdb3_v_detector u_v_detector (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sym     (hdb3_data),
        .is_mark (is_mark),
        .is_v    (is_v)
    );

    always_comb begin
        sr_d        = sr_q;
        m_d         = m_q;
        fill_d      = fill_q;
        decoded_d   = decoded_q;
        out_valid_d = 1'b0;
        code_err_d  = 1'b0;
        v_count_d   = v_count_q;
        if (en) begin
            decoded_d   = sr_q[3];
            // A V wipes the three younger entries and enters as zero, so the whole
            // B00V / 000V group collapses to zeros; sr[3] has already left.
            sr_d        = is_v ? 4'b0000 : {sr_q[2:0], is_mark};
            m_d         = {m_q[0], is_mark};
            out_valid_d = (fill_q == FILL_MAX);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 3'd1;
            end
            code_err_d  = sym_is_illegal(hdb3_data) || (is_v && (m_q != 2'b00));
            if (is_v && (v_count_q != {CNT_W{1'b1}})) begin
                v_count_d = v_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q        <= 4'b0000;
            m_q         <= 2'b00;
            fill_q      <= 3'd0;
            decoded_q   <= 1'b0;
            out_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
            v_count_q   <= '0;
        end else begin
            sr_q        <= sr_d;
            m_q         <= m_d;
            fill_q      <= fill_d;
            decoded_q   <= decoded_d;
            out_valid_q <= out_valid_d;
            code_err_q  <= code_err_d;
            v_count_q   <= v_count_d;
        end
    end

    assign decoded_data = decoded_q;
    assign out_valid    = out_valid_q;
    assign code_err     = code_err_q;
    assign v_count      = v_count_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// tb_hdb3_decoder: directed-vector bench with a scoreboard queue for decoded bits.
module tb_hdb3_decoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  hdb3_data;
    logic        decoded_data;
    logic        out_valid;
    logic        code_err;
    logic [15:0] v_count;

    logic        decoded_data_s;
    logic        out_valid_s;
    logic        code_err_s;
    logic [1:0]  v_count_s;

    int n_tests = 0;
    int n_fail  = 0;
    int n_edges = 0;

    logic       exp_q[$];
    logic [1:0] s_q[$];
    logic       b_q[$];
    logic       e_q[$];

    hdb3_decoder #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .hdb3_data    (hdb3_data),
        .decoded_data (decoded_data),
        .out_valid    (out_valid),
        .code_err     (code_err),
        .v_count      (v_count)
    );

    hdb3_decoder #(.CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .hdb3_data    (hdb3_data),
        .decoded_data (decoded_data_s),
        .out_valid    (out_valid_s),
        .code_err     (code_err_s),
        .v_count      (v_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every out_valid strobe consumes one expected bit.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL decoded_data: out_valid with empty scoreboard at %0t", $time);
            end else begin
                logic exp_bit;
                exp_bit = exp_q.pop_front();
                if (decoded_data !== exp_bit) begin
                    n_fail++;
                    $display("FAIL decoded_data: got %0b expected %0b at %0t",
                             decoded_data, exp_bit, $time);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] sym, input logic exp_bit, input logic exp_err,
                         input int gap);
        logic exp_valid;
        logic held;
        exp_valid = (n_edges >= 4);
        hdb3_data = sym;
        en        = 1'b1;
        exp_q.push_back(exp_bit);
        @(posedge clk);
        #1;
        n_edges++;
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        check("code_err", {31'd0, code_err}, {31'd0, exp_err});
        en        = 1'b0;
        hdb3_data = 2'b00;
        held      = decoded_data;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            check("gap out_valid", {31'd0, out_valid}, 32'd0);
            check("gap code_err", {31'd0, code_err}, 32'd0);
            check("gap decoded_hold", {31'd0, decoded_data}, {31'd0, held});
        end
    endtask

    task automatic run_seq(input int gap);
        for (int i = 0; i < s_q.size(); i++) begin
            drive(s_q[i], b_q[i], e_q[i], gap);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 1'b0, 1'b0, 0);
        end
    endtask

    // Asynchronous reset between clock edges; in-flight expectations are discarded.
    task automatic do_reset();
        int inflight;
        #3;
        rst = 1'b1;
        #1;
        check("rst decoded_data", {31'd0, decoded_data}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst code_err", {31'd0, code_err}, 32'd0);
        check("rst v_count", {16'd0, v_count}, 32'd0);
        inflight = (n_edges < 4) ? n_edges : 4;
        check("inflight count", exp_q.size(), inflight);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        n_edges = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        hdb3_data = 2'b00;
        #2;
        check("reset decoded_data", {31'd0, decoded_data}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset code_err", {31'd0, code_err}, 32'd0);
        check("reset v_count", {16'd0, v_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 000V: V at symbol 5
        s_q = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        b_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_seq(0);
        flush();
        check("000V v_count", {16'd0, v_count}, 32'd1);
        do_reset();

        // B00V: B at symbol 3, V at symbol 6
        s_q = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        b_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_seq(0);
        flush();
        check("B00V v_count", {16'd0, v_count}, 32'd1);
        do_reset();

        // 000V again with three idle cycles after every symbol
        s_q = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        b_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_seq(3);
        flush();
        check("gap v_count", {16'd0, v_count}, 32'd1);
        do_reset();

        // Illegal code at symbol 2; clean V at symbol 5
        s_q = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
        b_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        run_seq(0);
        flush();
        check("illegal v_count", {16'd0, v_count}, 32'd1);
        do_reset();

        // Malformed V: the V clears symbol 1 along with the group
        s_q = '{2'b01, 2'b00, 2'b01};
        b_q = '{1'b0, 1'b0, 1'b0};
        e_q = '{1'b0, 1'b0, 1'b1};
        run_seq(0);
        flush();
        check("malformed v_count", {16'd0, v_count}, 32'd1);
        do_reset();

        // Six +1 pulses: five back-to-back V events, each malformed
        s_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        b_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_seq(0);
        check("sat v_count wide", {16'd0, v_count}, 32'd5);
        check("sat v_count narrow", {30'd0, v_count_s}, 32'd3);

        // Three more symbols then an asynchronous reset mid-stream
        s_q = '{2'b11, 2'b00, 2'b00};
        b_q = '{1'b1, 1'b0, 1'b0};
        e_q = '{1'b0, 1'b0, 1'b0};
        run_seq(0);
        check("pre-rst v_count", {16'd0, v_count}, 32'd5);
        do_reset();
        check("post-rst narrow v_count", {30'd0, v_count_s}, 32'd0);

        // After reset: -1 first must not be V; out_valid resumes on the 5th symbol
        s_q = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        b_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_seq(0);
        check("restart v_count", {16'd0, v_count}, 32'd0);
        check("restart inflight", exp_q.size(), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
